// File: rtl/counter_ctrl_pkg.sv
// Shared types and helpers for the press-and-hold step counter controller.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    REPEAT       = 2'd1,
    LOCKOUT      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Width of the repeat timer; it only ever holds HOLD_CYCLES-1 or REPEAT_CYCLES-1.
  function automatic int timer_width(input int hold_cycles, input int repeat_cycles);
    int longest;
    longest = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
    return (longest > 2) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// Synchronises one raw active-low switch and debounces it into an active-high pressed level.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic switch_i,
  output logic pressed_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic [CW-1:0] cnt_q;

  // Inverting ahead of the synchroniser lets reset clear every flop to "released".
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q1   <= 1'b0;
      sync_q2   <= 1'b0;
      cnt_q     <= '0;
      pressed_o <= 1'b0;
    end else begin
      sync_q1 <= ~switch_i;
      sync_q2 <= sync_q1;
      if (sync_q2 != pressed_o) begin
        if (cnt_q == CNT_LAST) begin
          pressed_o <= sync_q2;
          cnt_q     <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/counter_step_ctrl.sv
// Press-and-hold controller issuing inc/dec strobes with auto-repeat and up/down lockout.
//
//   state        | meaning
//   IDLE         | no switch active, waiting for a single press
//   REPEAT       | one switch held, timer counting to the next auto-repeat pulse
//   LOCKOUT      | both switches seen pressed, no pulses until both released
//   RELEASE_WAIT | one-cycle gap after lockout before re-arming
module counter_step_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 16,
  parameter int REPEAT_CYCLES   = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic switch_up_i,
  input  logic switch_down_i,
  output logic inc_o,
  output logic dec_o,
  output logic held_o,
  output logic conflict_o
);

  localparam int TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 1);

  logic          up_pressed;
  logic          down_pressed;
  logic          active_pressed;
  logic          other_pressed;
  state_t        state_q;
  dir_t          dir_q;
  logic [TW-1:0] timer_q;

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .switch_i  (switch_up_i),
    .pressed_o (up_pressed)
  );

  sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_down (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .switch_i  (switch_down_i),
    .pressed_o (down_pressed)
  );

  assign active_pressed = (dir_q == DIR_UP) ? up_pressed : down_pressed;
  assign other_pressed  = (dir_q == DIR_UP) ? down_pressed : up_pressed;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      dir_q      <= DIR_UP;
      timer_q    <= '0;
      inc_o      <= 1'b0;
      dec_o      <= 1'b0;
      held_o     <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      inc_o <= 1'b0;
      dec_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (up_pressed && down_pressed) begin
            state_q    <= LOCKOUT;
            conflict_o <= 1'b1;
          end else if (up_pressed || down_pressed) begin
            dir_q   <= up_pressed ? DIR_UP : DIR_DOWN;
            inc_o   <= up_pressed;
            dec_o   <= down_pressed;
            timer_q <= HOLD_LOAD;
            state_q <= REPEAT;
            held_o  <= 1'b1;
          end
        end
        REPEAT: begin
          // Release wins over a simultaneous press of the opposite switch.
          if (!active_pressed) begin
            state_q <= IDLE;
            held_o  <= 1'b0;
          end else if (other_pressed) begin
            state_q    <= LOCKOUT;
            held_o     <= 1'b0;
            conflict_o <= 1'b1;
          end else if (timer_q == '0) begin
            inc_o   <= (dir_q == DIR_UP);
            dec_o   <= (dir_q == DIR_DOWN);
            timer_q <= REPEAT_LOAD;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        LOCKOUT: begin
          if (!up_pressed && !down_pressed) begin
            state_q    <= RELEASE_WAIT;
            conflict_o <= 1'b0;
          end
        end
        RELEASE_WAIT: begin
          state_q <= IDLE;
        end
        default: begin
          state_q    <= IDLE;
          held_o     <= 1'b0;
          conflict_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_step_ctrl.sv
// Scoreboard bench for counter_step_ctrl: directed scenarios plus random switch activity.
module tb_counter_step_ctrl;

  localparam int DEB  = 4;
  localparam int HOLD = 16;
  localparam int REP  = 8;

  localparam int M_IDLE = 0, M_HOLD = 1, M_LOCK = 2, M_GAP = 3;

  logic clk_i = 1'b0;
  logic reset_i;
  logic switch_up_i;
  logic switch_down_i;
  logic inc_o, dec_o, held_o, conflict_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {int edge_n; bit is_up;} pulse_t;
  typedef struct {bit held; bit conflict;} stat_t;
  pulse_t exp_pulses[$];
  stat_t  exp_stat[$];

  int drv_edge = 0;
  int mon_edge = 0;

  // Reference model state (index 0 = up switch, 1 = down switch)
  bit [1:0] m_s1, m_s2, m_lvl;
  int       m_run [2];
  int       m_mode;
  bit       m_up_dir;
  int       m_due;

  counter_step_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .HOLD_CYCLES    (HOLD),
    .REPEAT_CYCLES  (REP)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .switch_up_i  (switch_up_i),
    .switch_down_i(switch_down_i),
    .inc_o        (inc_o),
    .dec_o        (dec_o),
    .held_o       (held_o),
    .conflict_o   (conflict_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic push_pulse(input int e, input bit up);
    pulse_t p;
    p.edge_n = e;
    p.is_up  = up;
    exp_pulses.push_back(p);
  endtask

  // Predicts the effect of edge e given the inputs presented before it.
  task automatic model_edge(input bit up_n, input bit dn_n, input bit rst, input int e);
    bit [1:0] seen;
    bit       pu, pd, act, oth;
    stat_t    s;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      m_run[0] = 0; m_run[1] = 0;
      m_mode = M_IDLE;
    end else begin
      seen = m_lvl;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB) begin
            m_lvl[i] = m_s2[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = {~dn_n, ~up_n};
      pu = seen[0];
      pd = seen[1];
      case (m_mode)
        M_IDLE: begin
          if (pu && pd) m_mode = M_LOCK;
          else if (pu || pd) begin
            m_up_dir = pu;
            push_pulse(e, pu);
            m_due  = e + HOLD;
            m_mode = M_HOLD;
          end
        end
        M_HOLD: begin
          act = m_up_dir ? pu : pd;
          oth = m_up_dir ? pd : pu;
          if (!act) m_mode = M_IDLE;
          else if (oth) m_mode = M_LOCK;
          else if (e == m_due) begin
            push_pulse(e, m_up_dir);
            m_due = e + REP;
          end
        end
        M_LOCK: if (!pu && !pd) m_mode = M_GAP;
        default: m_mode = M_IDLE;
      endcase
    end
    s.held     = (m_mode == M_HOLD);
    s.conflict = (m_mode == M_LOCK);
    exp_stat.push_back(s);
  endtask

  task automatic step(input bit up_n, input bit dn_n, input bit rst);
    switch_up_i   = up_n;
    switch_down_i = dn_n;
    reset_i       = rst;
    model_edge(up_n, dn_n, rst, drv_edge);
    @(posedge clk_i);
    #1;
    drv_edge++;
  endtask

  task automatic run(input bit up_pr, input bit dn_pr, input bit rst, input int n);
    for (int i = 0; i < n; i++) step(~up_pr, ~dn_pr, rst);
  endtask

  // Monitor: the negedge after edge k checks what edge k produced.
  initial begin
    stat_t  s;
    pulse_t p;
    forever begin
      @(negedge clk_i);
      if (exp_stat.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL stat_queue edge %0d: no expectation queued", mon_edge);
      end else begin
        s = exp_stat.pop_front();
        n_cmp++;
        if (held_o !== s.held) begin
          n_err++;
          $display("FAIL held edge %0d: got %b want %b", mon_edge, held_o, s.held);
        end
        n_cmp++;
        if (conflict_o !== s.conflict) begin
          n_err++;
          $display("FAIL conflict edge %0d: got %b want %b", mon_edge, conflict_o, s.conflict);
        end
      end
      if (inc_o === 1'b1 && dec_o === 1'b1) begin
        n_cmp++; n_err++;
        $display("FAIL exclusive edge %0d: inc=1 dec=1 want at most one", mon_edge);
      end
      if (inc_o === 1'b1 || dec_o === 1'b1) begin
        n_cmp++;
        if (exp_pulses.size() == 0 || exp_pulses[0].edge_n != mon_edge) begin
          n_err++;
          $display("FAIL unexpected_pulse edge %0d: inc=%b dec=%b want none", mon_edge, inc_o, dec_o);
        end else begin
          p = exp_pulses.pop_front();
          if (inc_o !== p.is_up || dec_o !== !p.is_up) begin
            n_err++;
            $display("FAIL pulse_dir edge %0d: inc=%b dec=%b want inc=%b dec=%b",
                     mon_edge, inc_o, dec_o, p.is_up, !p.is_up);
          end
        end
      end else if (exp_pulses.size() != 0 && exp_pulses[0].edge_n == mon_edge) begin
        n_cmp++; n_err++;
        p = exp_pulses.pop_front();
        $display("FAIL missing_pulse edge %0d: inc=%b dec=%b want %s", mon_edge, inc_o, dec_o,
                 p.is_up ? "inc" : "dec");
      end else if (inc_o !== 1'b0 || dec_o !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL pulse_level edge %0d: inc=%b dec=%b want 0", mon_edge, inc_o, dec_o);
      end
      mon_edge++;
    end
  end

  initial begin
    int pat, len;
    run(0, 0, 1, 3);
    run(0, 0, 0, 5);
    // single press and release
    run(1, 0, 0, 10);
    run(0, 0, 0, 20);
    // long down hold into auto-repeat
    run(0, 1, 0, 50);
    run(0, 0, 0, 20);
    // short glitch
    run(1, 0, 0, 3);
    run(0, 0, 0, 12);
    // both pressed together, then a clean up press
    run(1, 1, 0, 20);
    run(0, 0, 0, 1);
    run(1, 0, 0, 10);
    run(0, 0, 0, 20);
    // down pressed during up repeat, then hand over to down only
    run(1, 0, 0, 25);
    run(1, 1, 0, 10);
    run(0, 1, 0, 15);
    run(0, 0, 0, 10);
    run(0, 1, 0, 10);
    run(0, 0, 0, 20);
    // reset in the middle of a hold
    run(1, 0, 0, 20);
    run(1, 0, 1, 2);
    run(1, 0, 0, 40);
    run(0, 0, 0, 20);
    // random activity
    for (int seg = 0; seg < 80; seg++) begin
      pat = $urandom_range(0, 3);
      len = $urandom_range(1, 45);
      if ($urandom_range(0, 14) == 0) run(pat[0], pat[1], 1, $urandom_range(1, 2));
      run(pat[0], pat[1], 0, len);
    end
    run(0, 0, 0, 30);
    @(negedge clk_i);
    #1;
    n_cmp++;
    if (exp_pulses.size() != 0) begin
      n_err++;
      $display("FAIL leftover_pulses: got %0d pending want 0", exp_pulses.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
